// File: rtl/serializer12_tx.sv
// 12-bit parallel-to-serial transmitter: one-word holding buffer feeding an MSB-first shifter.
// Back-to-back words leave with no idle bit between frames.
//
// state    | meaning
// ST_IDLE  | shifter empty; a held word moves into it on the next edge
// ST_SHIFT | frame on the link; ser_valid high, one bit per accepted beat
module serializer12_tx #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_data_in,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  output logic             o_ser_out,
  output logic             o_ser_valid,
  input  logic             i_out_ready,
  output logic             o_ser_first,
  output logic             o_ser_last,
  output logic [7:0]       o_words_sent
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_hold_data;
  logic             r_hold_full;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_bitcnt;
  logic [7:0]       r_words_sent;

  logic w_accept;
  logic w_beat;
  logic w_last_beat;
  logic w_load;

  assign w_accept = i_in_valid && !r_hold_full;

  always_comb begin
    w_state_nxt = r_state;
    w_beat      = 1'b0;
    w_last_beat = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_beat      = i_out_ready;
        w_last_beat = i_out_ready && (r_bitcnt == LAST_CNT);
        if (w_last_beat) begin
          // A waiting word chains straight into the shifter with no gap bit.
          w_load = r_hold_full;
          if (!r_hold_full) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_data  <= '0;
      r_hold_full  <= 1'b0;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_words_sent <= '0;
    end else begin
      if (w_accept) begin
        r_hold_data <= i_data_in;
        r_hold_full <= 1'b1;
      end else if (w_load) begin
        r_hold_full <= 1'b0;
      end

      if (w_load) begin
        r_shreg  <= r_hold_data;
        r_bitcnt <= '0;
      end else if (w_beat) begin
        // The final shift empties the register, so ser_out idles at 0.
        r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
        r_bitcnt <= w_last_beat ? '0 : r_bitcnt + CNT_W'(1);
      end

      if (w_last_beat) begin
        r_words_sent <= r_words_sent + 8'd1;
      end
    end
  end

  assign o_in_ready   = !r_hold_full;
  assign o_ser_valid  = (r_state == ST_SHIFT);
  assign o_ser_out    = r_shreg[WIDTH-1];
  assign o_ser_first  = (r_state == ST_SHIFT) && (r_bitcnt == '0);
  assign o_ser_last   = (r_state == ST_SHIFT) && (r_bitcnt == LAST_CNT);
  assign o_words_sent = r_words_sent;

endmodule

// File: doc/serializer12_tx.md
# serializer12_tx

Parallel-to-serial transmitter for 12-bit words: it accepts a word on a valid/ready handshake and shifts it out MSB-first, one bit per accepted output beat. It is the read-out end of the 12-bit register datapath, draining registered words onto a 1-bit link. A one-word holding buffer decouples the producer from the shifter, so back-to-back words go out with no idle bit between frames.

## Interface
- WIDTH, 12, word width; the shifter, holding buffer and bit counter scale with it.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset. rst=0 clears all state immediately.
- data_in  input  WIDTH  parallel word from the producer.
- in_valid  input  1  data_in is valid.
- in_ready  output  1  holding buffer empty; the word is accepted on an edge where in_valid && in_ready.
- ser_out  output  1  current serial bit, which is shifter MSB.
- ser_valid  output  1  ser_out carries a frame bit.
- out_ready  input  1  consumer takes the bit on an edge where ser_valid && out_ready.
- ser_first  output  1  current bit is bit WIDTH-1 of the frame (first bit sent).
- ser_last  output  1  current bit is bit 0 of the frame (last bit sent).
- words_sent  output  8  count of completed frames, wrapping from 255 to 0.

## Operation
- State: holding buffer (hold_data, hold_full), shifter (shreg), bit counter (bitcnt, 0..WIDTH-1), FSM {IDLE, SHIFT}.
- Reset values: hold_full=0, in_ready=1, shreg=0, ser_out=0, bitcnt=0, FSM=IDLE, ser_valid=0, ser_first=0, ser_last=0, words_sent=0.
- in_ready = !hold_full. This is registered state, with no combinational path from out_ready.
- Accept: in_valid && in_ready loads hold_data and sets hold_full.
- IDLE: when hold_full, the next edge does the following:
  - shreg <= hold_data
  - bitcnt <= 0
  - hold_full <= 0
  - FSM <= SHIFT
- SHIFT: ser_valid=1 and ser_out=shreg[WIDTH-1].
  - ser_first = (bitcnt==0).
  - ser_last = (bitcnt==WIDTH-1).
- A beat is ser_valid && out_ready. On a beat that is not the last: shreg shifts left with 0 fill, and bitcnt increments.
- On the last beat, words_sent increments, then:
  - If hold_full, shreg <= hold_data, bitcnt <= 0, hold_full <= 0, and the FSM stays in SHIFT. This is the back-to-back case with no gap.
  - Otherwise the FSM goes to IDLE and ser_valid drops.
- When out_ready=0, ser_out, ser_first and ser_last hold unchanged indefinitely.
- Input acceptance runs independently of shifting. in_ready rises the cycle after the holding buffer transfers to the shifter.
- Transfer and accept never occur on the same edge, because acceptance requires hold_full=0.
- Reset asserted mid-frame drops the partial frame and any held word. Outputs go to their reset values asynchronously, with no completion counted.

## Timing
- A word accepted at edge N transfers to the shifter at edge N+1.
- Its first bit is visible with ser_valid=1 after edge N+1.
- With out_ready held at 1, a frame occupies exactly WIDTH cycles.
- Continuous streaming gives a throughput of 1 bit/cycle, with ser_valid high continuously.
- After a last beat, words_sent shows the new value from the following cycle.
- rst deassertion is sampled at clock edges; the first acceptance can happen on the first edge with rst=1.

## Test plan
- Reset:
  - Stimulus: rst=0 for 2 cycles mid-frame, then rst=1.
  - Required: in_ready=1, ser_valid=0, words_sent=0. No bits are emitted until a new word is accepted.
- Single word:
  - Stimulus: data_in=12'hA5C, out_ready=1.
  - Required: ser_out sequence is 1,0,1,0,0,1,0,1,1,1,0,0.
  - Required: ser_first on bit 1, ser_last on bit 12, then ser_valid=0 and words_sent=1.
- Back-to-back:
  - Stimulus: 12'hFFF then 12'h001, both offered while the first is shifting.
  - Required: 24 consecutive ser_valid cycles; bits are twelve 1s, eleven 0s, then 1; words_sent=2.
- Backpressure:
  - Stimulus: send 12'h800, and drop out_ready for 5 cycles after bit 1.
  - Required: ser_out stays 1 and ser_first stays 1 during the stall. Shifting resumes with 0s and completes the frame of 12 bits.
- Buffer full:
  - Stimulus: hold in_valid=1 continuously with new values while out_ready=0.
  - Required: in_ready=0 after one word is held and one is in the shifter. No word is lost or overwritten.
- Wrap:
  - Stimulus: send 256 words.
  - Required: words_sent returns to 0; a 257th word gives words_sent=1.
